lsu_ram_port: RTL and testbench
===============================

// Module: lsu_ram_port
// PURPOSE
//  Load/store unit sitting between the core's memory stage and the byte-addressed data RAM.
//  Decodes RISC-V load/store width (LB/LH/LW/LBU/LHU/SB/SH/SW) into the RAM's rw_len code.
//  Sequences the access in one cycle, sign/zero-extends load data and reports misaligned/out-of-range faults.
//  Uses a valid/ready request and response handshake toward the core.
// PARAMETERS
//  RAM_WIDTH   10   RAM address MSB index; RAM spans 2**RAM_WIDTH bytes, ram_addr is RAM_WIDTH+1 bits
// PORTS
//  clk          in   1            single clock, rising edge
//  rst          in   1            asynchronous, active-high reset
//  req_valid    in   1            core presents a memory op
//  req_ready    out  1            LSU can accept (IDLE only)
//  req_we       in   1            1=store, 0=load
//  req_funct3   in   3            RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32           byte address
//  req_wdata    in   32           store data, LSB-aligned
//  rsp_valid    out  1            result/fault available
//  rsp_ready    in   1            core consumes response
//  rsp_rdata    out  32           extended load data (0 for stores and faults)
//  rsp_exc      out  2            00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
//  rsp_exc_addr out  32           faulting req_addr (0 when rsp_exc=00)
//  ram_rw_len   out  3            [2]=write strobe, [1:0] 00 byte, 01 half, 10 word
//  ram_addr     out  RAM_WIDTH+1  RAM byte address
//  ram_write    out  32           RAM write data
//  ram_read     in   32           RAM combinational read data, LSB-aligned
//  ram_exception in  1            RAM alignment flag (cross-check only)
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_exc=00, rsp_exc_addr=0,
//   ram_rw_len=3'b000, ram_addr=0, ram_write=0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: req_ready=1; on req_valid register we/funct3/addr/wdata and precheck, go ACCESS (or RESP on fault).
//  Precheck, priority order: funct3 not in {000,001,010,100,101} or (req_we & funct3[2]) -> 11;
//   half with addr[0]=1 or word with addr[1:0]!=0 -> 01; addr[31:RAM_WIDTH+1]!=0 or last byte > 2**RAM_WIDTH-1 -> 10.
//  Faulting requests never drive the RAM; go straight to RESP.
//  ACCESS (exactly 1 cycle): ram_addr=addr[RAM_WIDTH:0], ram_rw_len={we,len}, ram_write=wdata.
//   Load: capture ram_read, extend: B sign from bit7, BU zero, H sign from bit15, HU zero, W as-is.
//   ram_exception=1 in ACCESS is an internal inconsistency: report 01; never expected.
//  RESP: rsp_valid=1, outputs stable until rsp_ready=1; same-cycle handshake returns to IDLE.
//  Latency: accept at cycle N -> rsp_valid at N+2 (N+1 for prechecked faults); 1 op in flight max.
//  ram_rw_len[2] is high ONLY in ACCESS for a legal store; all other states drive 3'b000, no stray writes.
//  ram_addr/ram_write return to 0 outside ACCESS.
//  Async reset mid-ACCESS: write strobe drops immediately, in-flight op is discarded, no response issued.
//  req_valid while not IDLE is ignored (req_ready=0); core must hold request until accepted.
// STRUCTURE
//  Package lsu_pkg: funct3 localparams (F3_B..F3_HU), rw_len codes (LEN_B/H/W),
//   exception codes (EXC_NONE/MISAL/ACCESS/ILLEGAL), FSM state enum.
//  Sub-module lsu_load_ext: combinational funct3 + 32b raw -> 32b extended data.
// TESTING
//  SW 0x12345678 @0x10, then LW @0x10 -> rsp_rdata=0x12345678, exc=00, rsp_valid 2 cycles after accept.
//  SB 0x000000F0 @0x21, LB @0x21 -> 0xFFFFFFF0; LBU @0x21 -> 0x000000F0.
//  LH @0x03 -> exc=01, exc_addr=0x03, ram_rw_len stays 000 throughout.
//  SW @0x400 with RAM_WIDTH=10 -> exc=10; LW @0x3FC -> ok; LW @0x3FE -> exc=01.
//  funct3=011 load and SB with funct3=100 -> exc=11, no RAM write observed.
//  Hold rsp_ready=0 for 5 cycles -> response stable, req_ready=0; assert rst during store ACCESS -> strobe low same cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RISC-V funct3 widths, RAM rw_len codes,
// exception codes and the access FSM states, plus small width-decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_MISAL   = 2'b01;
    localparam logic [1:0] EXC_ACCESS  = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Unsigned variants only exist for loads; a store with funct3[2] set is illegal.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] f3_len(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   f3_len = LEN_B;
            2'b01:   f3_len = LEN_H;
            default: f3_len = LEN_W;
        endcase
    endfunction

    function automatic logic [1:0] f3_size_m1(input logic [2:0] f3);
        case (f3_len(f3))
            LEN_B:   f3_size_m1 = 2'd0;
            LEN_H:   f3_size_m1 = 2'd1;
            default: f3_size_m1 = 2'd3;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3_len(f3))
            LEN_H:   f3_misaligned = addr_lo[0];
            LEN_W:   f3_misaligned = |addr_lo;
            default: f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load-data extension: turns LSB-aligned raw RAM data into the architectural
// register value according to the load's funct3 (sign or zero extension).
module lsu_load_ext
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = raw_i;
        case (funct3_i)
            F3_B:    data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_BU:   data_o = {24'd0, raw_i[7:0]};
            F3_H:    data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_HU:   data_o = {16'd0, raw_i[15:0]};
            default: data_o = raw_i;
        endcase
    end

endmodule

// File: rtl/lsu_ram_port.sv
// Load/store unit between the core memory stage and the byte-addressed data RAM:
// one op in flight, fault precheck at accept, single-cycle RAM access, held response.
module lsu_ram_port
    import lsu_pkg::*;
#(
    parameter int RAM_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_exc,
    output logic [31:0]          rsp_exc_addr,
    output logic [2:0]           ram_rw_len,
    output logic [RAM_WIDTH:0]   ram_addr,
    output logic [31:0]          ram_write,
    input  logic [31:0]          ram_read,
    input  logic                 ram_exception
);

    localparam logic [32:0] RAM_LAST = 33'((64'd1 << RAM_WIDTH) - 64'd1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  exc_q, exc_d;

    logic [1:0]  pre_exc;
    logic [32:0] last_byte;
    logic [31:0] ext_data;

    // Fault classification of the incoming request, highest priority first.
    always_comb begin
        last_byte = {1'b0, req_addr} + {31'd0, f3_size_m1(req_funct3)};
        if (!f3_legal(req_we, req_funct3)) begin
            pre_exc = EXC_ILLEGAL;
        end else if (f3_misaligned(req_funct3, req_addr[1:0])) begin
            pre_exc = EXC_MISAL;
        end else if ((|req_addr[31:RAM_WIDTH+1]) || (last_byte > RAM_LAST)) begin
            pre_exc = EXC_ACCESS;
        end else begin
            pre_exc = EXC_NONE;
        end
    end

    lsu_load_ext u_load_ext (
        .funct3_i (funct3_q),
        .raw_i    (ram_read),
        .data_o   (ext_data)
    );

    always_comb begin
        // NOTE: every output and _d signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        exc_d      = exc_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        ram_rw_len = 3'b000;
        ram_addr   = '0;
        ram_write  = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    exc_d    = pre_exc;
                    state_d  = (pre_exc == EXC_NONE) ? ST_ACCESS : ST_RESP;
                end
            end
            ST_ACCESS: begin
                // Only prechecked-legal ops reach here, so the write strobe is safe to raise.
                ram_addr   = addr_q[RAM_WIDTH:0];
                ram_rw_len = {we_q, f3_len(funct3_q)};
                ram_write  = wdata_q;
                if (ram_exception) begin
                    exc_d   = EXC_MISAL;
                    rdata_d = '0;
                end else if (!we_q) begin
                    rdata_d = ext_data;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rsp_rdata    = '0;
        rsp_exc      = EXC_NONE;
        rsp_exc_addr = '0;
        if (state_q == ST_RESP) begin
            rsp_rdata = rdata_q;
            rsp_exc   = exc_q;
            if (exc_q != EXC_NONE) begin
                rsp_exc_addr = addr_q;
            end
        end
    end

    // NOTE: registers update with non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            exc_q    <= EXC_NONE;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            exc_q    <= exc_d;
        end
    end

endmodule

// File: tb/tb_lsu_ram_port.sv
// Self-checking bench for lsu_ram_port: behavioural byte RAM, scoreboard of expected
// responses pushed at issue and popped when the response appears.
module tb_lsu_ram_port;
    import lsu_pkg::*;

    localparam int RAM_WIDTH = 10;

    logic               clk;
    logic               rst;
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [31:0]        req_addr;
    logic [31:0]        req_wdata;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_rdata;
    logic [1:0]         rsp_exc;
    logic [31:0]        rsp_exc_addr;
    logic [2:0]         ram_rw_len;
    logic [RAM_WIDTH:0] ram_addr;
    logic [31:0]        ram_write;
    logic [31:0]        ram_read;
    logic               ram_exception;

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  exc;
        logic [31:0] exc_addr;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   wr_cnt = 0;
    int   act_cnt = 0;
    logic [7:0] mem [0:2047] = '{default: 8'h00};
    int   ram_idx;

    lsu_ram_port #(.RAM_WIDTH(RAM_WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_funct3    (req_funct3),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_exc       (rsp_exc),
        .rsp_exc_addr  (rsp_exc_addr),
        .ram_rw_len    (ram_rw_len),
        .ram_addr      (ram_addr),
        .ram_write     (ram_write),
        .ram_read      (ram_read),
        .ram_exception (ram_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational LSB-aligned read, write on the rising edge.
    always_comb begin
        ram_idx = int'(ram_addr);
        case (ram_rw_len[1:0])
            LEN_B:   ram_read = {24'd0, mem[ram_idx]};
            LEN_H:   ram_read = {16'd0, mem[ram_idx+1], mem[ram_idx]};
            default: ram_read = {mem[ram_idx+3], mem[ram_idx+2], mem[ram_idx+1], mem[ram_idx]};
        endcase
    end

    always @(posedge clk) begin
        if (ram_rw_len[2]) begin
            mem[ram_idx] <= ram_write[7:0];
            if (ram_rw_len[1:0] != LEN_B) mem[ram_idx+1] <= ram_write[15:8];
            if (ram_rw_len[1:0] == LEN_W) begin
                mem[ram_idx+2] <= ram_write[23:16];
                mem[ram_idx+3] <= ram_write[31:24];
            end
        end
    end

    always @(negedge clk) begin
        if (ram_rw_len[2]) wr_cnt <= wr_cnt + 1;
        if (ram_rw_len != 3'b000 || ram_addr != '0 || ram_write != '0) act_cnt <= act_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic [1:0] exp_exc,
                         input int exp_lat, input int hold);
        exp_t e;
        exp_t got;
        int   waited;
        int   wr0;
        int   act0;
        int   exp_wr;
        e.rdata    = exp_rdata;
        e.exc      = exp_exc;
        e.exc_addr = (exp_exc != EXC_NONE) ? addr : 32'd0;
        sb_q.push_back(e);
        wr0  = wr_cnt;
        act0 = act_cnt;

        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        waited = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        n_cmp++;
        if (waited >= 20) begin
            $display("FAIL %s accept: req_ready never rose within %0d cycles", name, waited);
            n_bad++;
        end
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_funct3 = 3'b000;
        req_addr  = '0;
        req_wdata = '0;

        waited = 1;
        while (!rsp_valid && waited < 20) begin
            step();
            waited++;
        end
        n_cmp++;
        if (waited !== exp_lat) begin
            $display("FAIL %s latency: got %0d cycles, want %0d", name, waited, exp_lat);
            n_bad++;
        end
        if (!rsp_valid) begin
            void'(sb_q.pop_front());
            return;
        end

        got = sb_q.pop_front();
        n_cmp++;
        if (rsp_rdata !== got.rdata) begin
            $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, got.rdata);
            n_bad++;
        end
        n_cmp++;
        if (rsp_exc !== got.exc) begin
            $display("FAIL %s exc: got %b want %b", name, rsp_exc, got.exc);
            n_bad++;
        end
        n_cmp++;
        if (rsp_exc_addr !== got.exc_addr) begin
            $display("FAIL %s exc_addr: got %h want %h", name, rsp_exc_addr, got.exc_addr);
            n_bad++;
        end

        // Back-pressure: response must hold and a competing request must be refused.
        for (int i = 0; i < hold; i++) begin
            req_valid  = 1'b1;
            req_we     = 1'b1;
            req_funct3 = F3_W;
            req_addr   = 32'h60;
            req_wdata  = 32'hFFFF_FFFF;
            step();
            n_cmp++;
            if ({rsp_valid, req_ready, rsp_rdata, rsp_exc, rsp_exc_addr} !==
                {1'b1, 1'b0, got.rdata, got.exc, got.exc_addr}) begin
                $display("FAIL %s hold%0d: valid=%b ready=%b rdata=%h exc=%b want valid=1 ready=0 rdata=%h exc=%b",
                         name, i, rsp_valid, req_ready, rsp_rdata, rsp_exc, got.rdata, got.exc);
                n_bad++;
            end
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;

        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        n_cmp++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            $display("FAIL %s release: valid=%b ready=%b want valid=0 ready=1", name, rsp_valid, req_ready);
            n_bad++;
        end

        exp_wr = (we && exp_exc == EXC_NONE && exp_lat == 2) ? 1 : 0;
        n_cmp++;
        if (wr_cnt - wr0 !== exp_wr) begin
            $display("FAIL %s writes: got %0d strobe cycles want %0d", name, wr_cnt - wr0, exp_wr);
            n_bad++;
        end
        if (exp_lat == 1) begin
            n_cmp++;
            if (act_cnt - act0 !== 0) begin
                $display("FAIL %s ram idle: got %0d active cycles want 0", name, act_cnt - act0);
                n_bad++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b0; ram_exception = 1'b0;
        step();
        step();
        n_cmp++;
        if ({req_ready, rsp_valid} !== 2'b10) begin
            $display("FAIL reset handshake: ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
            n_bad++;
        end
        n_cmp++;
        if ({rsp_rdata, rsp_exc, rsp_exc_addr} !== 66'd0) begin
            $display("FAIL reset rsp: rdata=%h exc=%b exc_addr=%h want all 0", rsp_rdata, rsp_exc, rsp_exc_addr);
            n_bad++;
        end
        n_cmp++;
        if ({ram_rw_len, ram_addr, ram_write} !== '0) begin
            $display("FAIL reset ram: rw_len=%b addr=%h wdata=%h want all 0", ram_rw_len, ram_addr, ram_write);
            n_bad++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_word();
        issue("sw_10", 1'b1, F3_W, 32'h10, 32'h1234_5678, 32'h0, EXC_NONE, 2, 0);
        issue("lw_10", 1'b0, F3_W, 32'h10, 32'h0, 32'h1234_5678, EXC_NONE, 2, 0);
    endtask

    task automatic test_extend();
        issue("sb_21",  1'b1, F3_B,  32'h21, 32'h0000_00F0, 32'h0, EXC_NONE, 2, 0);
        issue("lb_21",  1'b0, F3_B,  32'h21, 32'h0, 32'hFFFF_FFF0, EXC_NONE, 2, 0);
        issue("lbu_21", 1'b0, F3_BU, 32'h21, 32'h0, 32'h0000_00F0, EXC_NONE, 2, 0);
        issue("lw_20",  1'b0, F3_W,  32'h20, 32'h0, 32'h0000_F000, EXC_NONE, 2, 0);
        issue("sh_30",  1'b1, F3_H,  32'h30, 32'hAAAA_8001, 32'h0, EXC_NONE, 2, 0);
        issue("lh_30",  1'b0, F3_H,  32'h30, 32'h0, 32'hFFFF_8001, EXC_NONE, 2, 0);
        issue("lhu_30", 1'b0, F3_HU, 32'h30, 32'h0, 32'h0000_8001, EXC_NONE, 2, 0);
        issue("lw_30",  1'b0, F3_W,  32'h30, 32'h0, 32'h0000_8001, EXC_NONE, 2, 0);
    endtask

    task automatic test_faults();
        issue("lh_03",     1'b0, F3_H,   32'h03,        32'h0, 32'h0, EXC_MISAL,   1, 0);
        issue("sw_400",    1'b1, F3_W,   32'h400,       32'h5555_5555, 32'h0, EXC_ACCESS, 1, 0);
        issue("sw_3fc",    1'b1, F3_W,   32'h3FC,       32'hCAFE_BABE, 32'h0, EXC_NONE, 2, 0);
        issue("lw_3fc",    1'b0, F3_W,   32'h3FC,       32'h0, 32'hCAFE_BABE, EXC_NONE, 2, 0);
        issue("lbu_3ff",   1'b0, F3_BU,  32'h3FF,       32'h0, 32'h0000_00CA, EXC_NONE, 2, 0);
        issue("lw_3fe",    1'b0, F3_W,   32'h3FE,       32'h0, 32'h0, EXC_MISAL,   1, 0);
        issue("lh_3ff",    1'b0, F3_H,   32'h3FF,       32'h0, 32'h0, EXC_MISAL,   1, 0);
        issue("lb_hi",     1'b0, F3_B,   32'h8000_0000, 32'h0, 32'h0, EXC_ACCESS,  1, 0);
        issue("ld_f3_011", 1'b0, 3'b011, 32'h10,        32'h0, 32'h0, EXC_ILLEGAL, 1, 0);
        issue("sbu_21",    1'b1, F3_BU,  32'h21,        32'h0000_0011, 32'h0, EXC_ILLEGAL, 1, 0);
        issue("st_f3_110", 1'b1, 3'b110, 32'h03,        32'h0, 32'h0, EXC_ILLEGAL, 1, 0);
        issue("lw_10_kept",1'b0, F3_W,   32'h10,        32'h0, 32'h1234_5678, EXC_NONE, 2, 0);
        issue("lbu_21_kept",1'b0, F3_BU, 32'h21,        32'h0, 32'h0000_00F0, EXC_NONE, 2, 0);
    endtask

    task automatic test_ram_exception();
        ram_exception = 1'b1;
        issue("ram_exc", 1'b0, F3_W, 32'h10, 32'h0, 32'h0, EXC_MISAL, 2, 0);
        ram_exception = 1'b0;
    endtask

    task automatic test_backpressure();
        issue("hold_lw", 1'b0, F3_W, 32'h10, 32'h0, 32'h1234_5678, EXC_NONE, 2, 5);
        issue("hold_flt", 1'b0, F3_H, 32'h05, 32'h0, 32'h0, EXC_MISAL, 1, 3);
        issue("lw_60", 1'b0, F3_W, 32'h60, 32'h0, 32'h0, EXC_NONE, 2, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 32'hA5A5_A5A5 ^ (32'h0101_0101 * (i + 1));
            issue("b2b_sw", 1'b1, F3_W, 32'h100 + 32'(4 * i), v, 32'h0, EXC_NONE, 2, 0);
        end
        for (int i = 0; i < 4; i++) begin
            v = 32'hA5A5_A5A5 ^ (32'h0101_0101 * (i + 1));
            issue("b2b_lw", 1'b0, F3_W, 32'h100 + 32'(4 * i), 32'h0, v, EXC_NONE, 2, 0);
        end
    endtask

    task automatic test_reset_mid_access();
        int wr0;
        int waited;
        wr0 = wr_cnt;
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = F3_W;
        req_addr   = 32'h50;
        req_wdata  = 32'hDEAD_BEEF;
        waited = 0;
        while (!req_ready && waited < 20) begin
            step();
            waited++;
        end
        step();
        req_valid = 1'b0;
        req_we    = 1'b0;
        n_cmp++;
        if (ram_rw_len !== {1'b1, LEN_W}) begin
            $display("FAIL rst_mid strobe_before: rw_len=%b want 110", ram_rw_len);
            n_bad++;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({ram_rw_len, ram_addr, ram_write, req_ready} !== {3'b000, 11'd0, 32'd0, 1'b1}) begin
            $display("FAIL rst_mid strobe_after: rw_len=%b addr=%h wdata=%h ready=%b want 000/0/0/1",
                     ram_rw_len, ram_addr, ram_write, req_ready);
            n_bad++;
        end
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                $display("FAIL rst_mid no_rsp%0d: rsp_valid=%b want 0", i, rsp_valid);
                n_bad++;
            end
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if (wr_cnt - wr0 !== 0) begin
            $display("FAIL rst_mid writes: got %0d strobe cycles want 0", wr_cnt - wr0);
            n_bad++;
        end
        issue("lw_50", 1'b0, F3_W, 32'h50, 32'h0, 32'h0, EXC_NONE, 2, 0);
    endtask

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_faults();
        test_ram_exception();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_access();
        n_cmp++;
        if (sb_q.size() !== 0) begin
            $display("FAIL scoreboard drain: %0d entries left, want 0", sb_q.size());
            n_bad++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
